// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a scanned 4-digit 7-segment bus back into a 16-bit frame.
// Define DP_CAPTURE_EN to synchronize, compare and report the decimal-point line per digit.
module seg7_scan_capture #(
  parameter bit SEG_ACT_LOW   = 1'b1,
  parameter bit DIG_ACT_LOW   = 1'b1,
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT       = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic [3:0]  dp_out,
  output logic        stale
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
`ifdef DP_CAPTURE_EN
  localparam int SW = 12;
  logic [SW-1:0] raw;
  assign raw = {dig, g, f, e, d, c, b, a, dp};
`else
  localparam int SW = 11;
  logic [SW-1:0] raw;
  logic          unused_dp;
  assign raw = {dig, g, f, e, d, c, b, a};
  assign unused_dp = dp;
`endif
  logic [SW-1:0] s1, s2, prev;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    sel, cap, pend_err, pend_dp;
  logic [15:0]   pend_nib;
  logic [6:0]    pat;
  logic [3:0]    nib;
  logic          dpv, onehot, same, fire, ill, full;
  assign sel = s2[SW-1 -: 4] ^ {4{DIG_ACT_LOW}};
  assign pat = s2[SW-5 -: 7] ^ {7{SEG_ACT_LOW}};
`ifdef DP_CAPTURE_EN
  assign dpv = s2[0] ^ SEG_ACT_LOW;
`else
  assign dpv = 1'b0;
`endif
  assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign same   = s2 == prev;
  assign fire   = onehot && same && cnt == CW'(STABLE_CYCLES - 2);
  assign full   = &cap;
  assign stale  = tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    nib = 4'h0;
    ill = 1'b0;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1          <= '0;
      s2          <= '0;
      prev        <= '0;
      cnt         <= '0;
      cap         <= '0;
      pend_nib    <= '0;
      pend_err    <= '0;
      pend_dp     <= '0;
      value       <= '0;
      digit_err   <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      tcnt        <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      // saturating at STABLE_CYCLES-1 keeps a held digit from re-capturing
      cnt  <= (!onehot || !same) ? '0 : (cnt == CW'(STABLE_CYCLES - 1)) ? cnt : cnt + 1'b1;
      cap  <= (full ? 4'b0 : cap) | (fire ? sel : 4'b0);
      for (int i = 0; i < 4; i++)
        if (fire && sel[i]) begin
          pend_nib[i*4 +: 4] <= nib;
          pend_err[i]        <= ill;
          pend_dp[i]         <= dpv;
        end
      frame_valid <= full;
      if (full) begin
        value     <= pend_nib;
        digit_err <= pend_err;
        dp_out    <= pend_dp;
      end
      tcnt <= full ? '0 : stale ? tcnt : tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed loopback of an active-low scanned display bus into seg7_scan_capture.
module tb_seg7_scan_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  dig;
  logic [15:0] value;
  logic        frame_valid, stale;
  logic [3:0]  digit_err, dp_out;
  int total = 0, bad = 0;
  int cyc = 0, fv_cnt = 0, fv_cyc = 0, stale_cyc = 0;
  logic stale_q = 1'b0, fv_stale = 1'b0;
  logic [3:0] dp_exp;

  seg7_scan_capture #(
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1), .STABLE_CYCLES(16), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .dig(dig), .value(value), .frame_valid(frame_valid), .digit_err(digit_err),
    .dp_out(dp_out), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (frame_valid) begin
      fv_cnt++;
      fv_cyc   = cyc;
      fv_stale = stale;
    end
    if (stale && !stale_q) stale_cyc = cyc;
    stale_q = stale;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // dig_hi/pat/dpb are active-high views; the bus itself is driven active-low
  task automatic drive(input logic [3:0] dig_hi, input logic [6:0] pat, input logic dpb, input int n);
    dig = ~dig_hi;
    {g, f, e, d, c, b, a} = ~pat;
    dp = ~dpb;
    repeat (n) @(posedge clk);
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  initial begin
`ifdef DP_CAPTURE_EN
    dp_exp = 4'b0010;
`else
    dp_exp = 4'b0000;
`endif
    dig = 4'hF;
    {g, f, e, d, c, b, a} = 7'h7F;
    dp = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check("reset_value", value, 16'h0);
    check("reset_fv", frame_valid, 1'b0);
    check("reset_err", digit_err, 4'h0);
    check("reset_dp", dp_out, 4'h0);
    check("reset_stale", stale, 1'b0);
    rst = 1'b1;
    drive(4'b0001, 7'h7F, 1'b0, 32);
    drive(4'b0010, 7'h7F, 1'b0, 32);
    drive(4'b0100, 7'h7F, 1'b0, 32);
    settle();
    dig = 4'hF;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check("midreset_value", value, 16'h0);
    check("midreset_stale", stale, 1'b0);
    rst = 1'b1;
    drive(4'b1000, 7'h06, 1'b0, 64);
    drive(4'b0100, 7'h5B, 1'b0, 64);
    drive(4'b0010, 7'h4F, 1'b0, 64);
    settle();
    check("post_reset_three_no_frame", fv_cnt, 0);
    check("stale_before_first_frame", stale, 1'b1);
    drive(4'b0001, 7'h66, 1'b0, 64);
    drive(4'b0000, 7'h00, 1'b0, 4);
    settle();
    check("loop_fv_count", fv_cnt, 1);
    check("loop_value", value, 16'h1234);
    check("loop_err", digit_err, 4'h0);
    check("loop_fv_low", frame_valid, 1'b0);
    check("loop_stale_drop", fv_stale, 1'b0);
    check("loop_stale_after", stale, 1'b0);
    drive(4'b0000, 7'h00, 1'b0, 124);
    settle();
    check("stale_set", stale, 1'b1);
    check("stale_latency", stale_cyc - fv_cyc, 99);
    for (int i = 0; i < 12; i++) drive(4'b0001, i[0] ? 7'h5B : 7'h06, 1'b0, 8);
    settle();
    check("glitch_no_frame", fv_cnt, 1);
    drive(4'b0011, 7'h7F, 1'b0, 64);
    settle();
    check("ghost_no_frame", fv_cnt, 1);
    drive(4'b1000, 7'h71, 1'b0, 32);
    drive(4'b0100, 7'h00, 1'b0, 32);
    drive(4'b0010, 7'h71, 1'b0, 32);
    settle();
    check("illegal_partial", fv_cnt, 1);
    drive(4'b0001, 7'h71, 1'b0, 32);
    drive(4'b0000, 7'h00, 1'b0, 4);
    settle();
    check("illegal_fv_count", fv_cnt, 2);
    check("illegal_value", value, 16'hF0FF);
    check("illegal_err", digit_err, 4'b0100);
    check("illegal_stale_drop", fv_stale, 1'b0);
    check("illegal_dp", dp_out, 4'h0);
    drive(4'b0001, 7'h3F, 1'b0, 32);
    drive(4'b0010, 7'h3F, 1'b1, 32);
    drive(4'b0100, 7'h3F, 1'b0, 32);
    drive(4'b1000, 7'h3F, 1'b0, 32);
    drive(4'b0000, 7'h00, 1'b0, 4);
    settle();
    check("dp_fv_count", fv_cnt, 3);
    check("dp_value", value, 16'h0000);
    check("dp_err", digit_err, 4'h0);
    check("dp_out", dp_out, dp_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
